dpram_stream_reader: RTL and testbench

- Read-side master for one port of the dual-port block RAM.
- Accepts a burst command (base address, length) and issues sequential RAM reads, with wrap-around at DEPTH.
- Absorbs the RAM's 1-cycle read latency and presents the data as a valid/ready stream with a last flag.
- Typical use: drain sample buffers written by the other RAM port into downstream datapath engines.

---
 rtl/dpram_pkg.sv | 19 +
 rtl/skid_fifo2.sv | 50 +++++
 rtl/dpram_stream_reader.sv | 165 ++++++++++++++++
 tb/tb_dpram_stream_reader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared geometry and types for the dual-port RAM stream reader.
package dpram_pkg;

    localparam int DPRAM_DEPTH = 2048;
    localparam int DPRAM_AW    = 11;
    localparam int DPRAM_DW    = 32;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } rd_state_t;

    typedef struct packed {
        logic [DPRAM_AW-1:0] base;
        logic [DPRAM_AW:0]   len;
    } rd_cmd_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry valid/ready FIFO; the head stays put while the consumer stalls.
module skid_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_pop    = out_ready && (count != 2'd0);
    assign do_push   = in_valid && ((count != 2'd2) || do_pop);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dpram_stream_reader.sv
// Burst read master for one dual-port RAM port, streaming words out with a last flag.
// Define DPRAM_READER_STATS_EN to add the saturating stall_cnt output.
module dpram_stream_reader
    import dpram_pkg::*;
#(
    parameter int DEPTH = DPRAM_DEPTH,
    parameter int AW    = DPRAM_AW,
    parameter int DW    = DPRAM_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW:0]   cmd_len,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done
`ifdef DPRAM_READER_STATS_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    localparam logic [AW:0]   MAX_LEN  = DEPTH[AW:0];
    localparam logic [AW:0]   LEN_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    rd_state_t     state;
    rd_state_t     state_next;
    rd_cmd_t       cmd;
    logic [AW-1:0] addr;
    logic [AW:0]   rd_left;
    logic [AW:0]   beat_left;
    logic          inflight;
    logic          inflight_last;
    logic          done_zero;
    logic          accept;
    logic          issue;
    logic          pop;
    logic          fifo_valid;
    logic [DW:0]   fifo_head;
    logic [1:0]    fifo_count;
    logic [2:0]    occupancy;
    logic [2:0]    slot_limit;

    assign cmd.base = cmd_base;
    assign cmd.len  = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;

    assign accept = cmd_valid && (state == IDLE);
    assign pop    = fifo_valid && out_ready;

    // A beat leaving this cycle frees its slot, which sustains one read per cycle.
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight};
    assign slot_limit = 3'd2 + {2'b00, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        issue      = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (cmd.len != '0)) begin
                    state_next = READ;
                end
            end
            READ: begin
                busy = 1'b1;
                if ((rd_left != '0) && (occupancy < slot_limit)) begin
                    issue = 1'b1;
                end
                if (issue && (rd_left == LEN_ONE)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if ((beat_left == '0) || (pop && (beat_left == LEN_ONE))) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The last flag rides with each read so the FIFO hands it out with its data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr          <= '0;
            rd_left       <= '0;
            beat_left     <= '0;
            mem_addr      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done_zero     <= 1'b0;
        end else begin
            done_zero     <= accept && (cmd.len == '0);
            inflight      <= issue;
            inflight_last <= issue && (rd_left == LEN_ONE);
            if (accept) begin
                addr      <= cmd.base;
                rd_left   <= cmd.len;
                beat_left <= cmd.len;
            end
            if (issue) begin
                mem_addr <= addr;
                addr     <= addr + ADDR_ONE;
                rd_left  <= rd_left - LEN_ONE;
            end
            if (pop && (beat_left != '0)) begin
                beat_left <= beat_left - LEN_ONE;
            end
        end
    end

    skid_fifo2 #(
        .W(DW + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_valid (inflight),
        .in_data  ({inflight_last, mem_dout}),
        .out_valid(fifo_valid),
        .out_ready(out_ready),
        .out_data (fifo_head),
        .count    (fifo_count)
    );

    assign out_valid = fifo_valid;
    assign out_data  = fifo_head[DW-1:0];
    assign out_last  = fifo_valid && fifo_head[DW];
    assign done      = done_zero || (pop && (beat_left == LEN_ONE));
    assign mem_din   = '0;
    assign mem_we    = 1'b0;

`ifdef DPRAM_READER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed and randomized bursts against a queue-based model of the expected word stream.
module tb_dpram_stream_reader;
    import dpram_pkg::*;

    localparam int DEPTH = DPRAM_DEPTH;
    localparam int AW    = DPRAM_AW;
    localparam int DW    = DPRAM_DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_len;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
`ifdef DPRAM_READER_STATS_EN
    logic [31:0]   stall_cnt;
`endif

    logic [DW-1:0] ram [DEPTH];
    int            compared   = 0;
    int            mismatched = 0;
    int            rst_beats;
    int            rst_cycles;

    // RAM read port: the address register lives in the DUT, data follows one cycle later.
    assign mem_dout = ram[mem_addr];

    always #5 clk = ~clk;

    dpram_stream_reader dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_base (cmd_base),
        .cmd_len  (cmd_len),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_we   (mem_we),
        .mem_dout (mem_dout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .busy     (busy),
        .done     (done)
`ifdef DPRAM_READER_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // mode 0: out_ready held high; mode 1: out_ready random every cycle.
    task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW:0] len, input int mode);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] held_data;
        logic          held_last;
        logic          was_stalled;
        int            k;
        int            beats;
        int            first_valid;
        int            last_beat_k;
        int            stalls;
        int            budget;
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back(ram[(int'(base) + i) % DEPTH]);
        end
        budget      = 8 * int'(len) + 100;
        k           = 0;
        beats       = 0;
        first_valid = -1;
        last_beat_k = -1;
        stalls      = 0;
        was_stalled = 1'b0;
        held_data   = '0;
        held_last   = 1'b0;
        @(negedge clk);
        checkOutput("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_base  = base;
        cmd_len   = len;
        @(posedge clk);
        while (beats < int'(len) && k < budget) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (was_stalled) begin
                checkOutput("hold_valid", 64'(out_valid), 64'd1);
                checkOutput("hold_data", 64'(out_data), 64'(held_data));
                checkOutput("hold_last", 64'(out_last), 64'(held_last));
            end
            if (out_valid && first_valid < 0) begin
                first_valid = k;
            end
            if (out_valid && out_ready) begin
                beats++;
                checkOutput("beat_data", 64'(out_data), 64'(exp_q.pop_front()));
                checkOutput("beat_last", 64'(out_last), 64'(beats == int'(len)));
                checkOutput("beat_done", 64'(done), 64'(beats == int'(len)));
                if (beats == int'(len)) begin
                    last_beat_k = k;
                end
            end else begin
                checkOutput("no_done_between_beats", 64'(done), 64'd0);
            end
            checkOutput("busy_in_burst", 64'(busy), 64'd1);
            checkOutput("cmd_ready_in_burst", 64'(cmd_ready), 64'd0);
            if (out_valid && !out_ready) begin
                stalls++;
            end
            was_stalled = out_valid && !out_ready;
            held_data   = out_data;
            held_last   = out_last;
            k++;
        end
        checkOutput("beats_total", 64'(beats), 64'(len));
        if (mode == 0) begin
            checkOutput("first_valid_latency", 64'(first_valid), 64'd2);
            checkOutput("last_beat_cycle", 64'(last_beat_k), 64'(int'(len) + 1));
        end
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        checkIdle("after_burst");
`ifdef DPRAM_READER_STATS_EN
        checkOutput("stall_cnt", 64'(stall_cnt), 64'(stalls));
`endif
    endtask

    task automatic applyZeroLength(input logic [AW-1:0] base);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_base  = base;
        cmd_len   = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        checkOutput("zero_len_done", 64'(done), 64'd1);
        checkOutput("zero_len_cmd_ready", 64'(cmd_ready), 64'd1);
        checkOutput("zero_len_out_valid", 64'(out_valid), 64'd0);
        checkOutput("zero_len_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #1;
        checkIdle("zero_len_after");
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        out_ready = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            ram[a] = DW'(a) ^ 32'h0000_A5A5;
        end
        #12;
        checkIdle("reset");
        checkOutput("reset_out_data", 64'(out_data), 64'd0);
        checkOutput("reset_out_last", 64'(out_last), 64'd0);
        checkOutput("reset_mem_addr", 64'(mem_addr), 64'd0);
        checkOutput("reset_mem_we", 64'(mem_we), 64'd0);
        checkOutput("reset_mem_din", 64'(mem_din), 64'd0);
`ifdef DPRAM_READER_STATS_EN
        checkOutput("reset_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] short burst at 0x010");
        applyStimulus(AW'(16), (AW + 1)'(4), 0);
        $display("[TB] wrapping burst at DEPTH-2");
        applyStimulus(AW'(DEPTH - 2), (AW + 1)'(4), 0);
        $display("[TB] burst with random backpressure");
        applyStimulus(AW'($urandom_range(0, DEPTH - 1)), (AW + 1)'(8), 1);
        $display("[TB] zero-length command");
        applyZeroLength(AW'($urandom_range(0, DEPTH - 1)));
        $display("[TB] full-depth burst from 5");
        applyStimulus(AW'(5), (AW + 1)'(DEPTH), 0);

        $display("[TB] random bursts over random RAM contents");
        for (int t = 0; t < 6; t++) begin
            for (int a = 0; a < DEPTH; a++) begin
                ram[a] = $urandom;
            end
            applyStimulus(AW'($urandom_range(0, DEPTH - 1)), (AW + 1)'($urandom_range(1, 40)),
                          int'($urandom_range(0, 1)));
        end

        $display("[TB] reset during beat 3 of 10");
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_base  = AW'($urandom_range(0, DEPTH - 1));
        cmd_len   = (AW + 1)'(10);
        out_ready = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
        rst_beats  = 0;
        rst_cycles = 0;
        while (rst_beats < 3 && rst_cycles < 50) begin
            @(negedge clk);
            #1;
            if (out_valid && out_ready) begin
                rst_beats++;
            end
            rst_cycles++;
        end
        checkOutput("mid_reset_beat_reached", 64'(rst_beats), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        checkIdle("async_reset");
        checkOutput("async_reset_out_data", 64'(out_data), 64'd0);
        checkOutput("async_reset_out_last", 64'(out_last), 64'd0);
        checkOutput("async_reset_mem_addr", 64'(mem_addr), 64'd0);
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkIdle("after_reset_release");
        applyStimulus(AW'($urandom_range(0, DEPTH - 1)), (AW + 1)'(10), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
